// File: rtl/bsg_fifo_drain_serializer.sv
// Drains one wide word per FIFO yumi and replays it as chunk_width_p chunks on a ready/valid port.
// Define BSG_DRAIN_SERIALIZER_MSB_FIRST_EN to emit the most-significant chunk first (default: LSB first).
module bsg_fifo_drain_serializer #(
    parameter int width_p       = 32,
    parameter int chunk_width_p = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     v_i,
    input  logic [width_p-1:0]       data_i,
    output logic                     yumi_o,
    output logic                     v_o,
    output logic [chunk_width_p-1:0] data_o,
    output logic                     last_o,
    input  logic                     ready_i
);
    localparam int els_lp   = width_p / chunk_width_p;
    localparam int cnt_w_lp = $clog2(els_lp);
    localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(els_lp - 1);

    logic [width_p-1:0]  word_q, word_d;
    logic [cnt_w_lp-1:0] cnt_q, cnt_d;
    logic                full_q, full_d;
    logic                xfer;
    logic [els_lp-1:0][chunk_width_p-1:0] chunks;
    logic [cnt_w_lp-1:0] sel;

    assign chunks = word_q;

`ifdef BSG_DRAIN_SERIALIZER_MSB_FIRST_EN
    assign sel = last_cnt_lp - cnt_q;
`else
    assign sel = cnt_q;
`endif

    // Reset gates the valids so nothing leaks out during the reset cycle itself.
    assign v_o    = reset_n_i & full_q;
    assign last_o = v_o & (cnt_q == last_cnt_lp);
    assign data_o = chunks[sel];
    assign xfer   = v_o & ready_i;
    assign yumi_o = reset_n_i & v_i & (~full_q | (last_o & ready_i));

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        full_d = full_q;
        if (xfer) begin
            if (last_o) begin
                cnt_d  = '0;
                full_d = 1'b0;
            end else begin
                cnt_d = cnt_q + cnt_w_lp'(1);
            end
        end
        // A reload on the last chunk overrides the drain, giving zero-bubble streaming.
        if (yumi_o) begin
            word_d = data_i;
            cnt_d  = '0;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            full_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            full_q <= full_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        word_q <= word_d;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        assert (width_p % chunk_width_p == 0);
        assert (els_lp >= 2);
        assert (!(yumi_o && !v_i));
    end
`endif

endmodule

// File: tb/tb_bsg_fifo_drain_serializer.sv
// Randomized and directed bench for bsg_fifo_drain_serializer with a chunk-queue scoreboard.
module tb_bsg_fifo_drain_serializer;
    localparam int W = 32;
    localparam int C = 8;
    localparam int E = W / C;

    typedef struct {
        logic [C-1:0] d;
        logic         last;
    } chunk_t;

    logic         clk_i = 1'b0;
    logic         reset_n_i;
    logic         v_i;
    logic [W-1:0] data_i;
    logic         yumi_o;
    logic         v_o;
    logic [C-1:0] data_o;
    logic         last_o;
    logic         ready_i;

    int checks = 0;
    int errors = 0;
    chunk_t exp_q[$];
    logic         prev_stall = 1'b0;
    logic [C-1:0] prev_data;
    logic         prev_last;

    bsg_fifo_drain_serializer #(.width_p(W), .chunk_width_p(C)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .data_i(data_i),
        .yumi_o(yumi_o), .v_o(v_o), .data_o(data_o), .last_o(last_o), .ready_i(ready_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [C-1:0] chunk(input logic [W-1:0] w, input int k);
`ifdef BSG_DRAIN_SERIALIZER_MSB_FIRST_EN
        return C'(w >> ((E - 1 - k) * C));
`else
        return C'(w >> (k * C));
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: the queue holds the chunks still owed by the currently held word.
    always @(negedge clk_i) begin
        if (!reset_n_i) begin
            chk("rst_v_o", 32'(v_o), 0);
            chk("rst_yumi_o", 32'(yumi_o), 0);
            chk("rst_last_o", 32'(last_o), 0);
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            chk("mon_v_o", 32'(v_o), 32'(exp_q.size() != 0));
            chk("mon_yumi_o", 32'(yumi_o),
                32'(v_i && (exp_q.size() == 0 || (exp_q.size() == 1 && ready_i))));
            if (exp_q.size() != 0) begin
                chk("mon_data_o", 32'(data_o), 32'(exp_q[0].d));
                chk("mon_last_o", 32'(last_o), 32'(exp_q[0].last));
            end else begin
                chk("mon_last_idle", 32'(last_o), 0);
            end
            if (prev_stall) begin
                chk("hold_data", 32'(data_o), 32'(prev_data));
                chk("hold_last", 32'(last_o), 32'(prev_last));
            end
            prev_stall = v_o && !ready_i;
            prev_data  = data_o;
            prev_last  = last_o;
            if (v_o && ready_i && exp_q.size() != 0) void'(exp_q.pop_front());
            if (yumi_o) begin
                for (int k = 0; k < E; k++) begin
                    chunk_t c;
                    c.d    = chunk(data_i, k);
                    c.last = (k == E - 1);
                    exp_q.push_back(c);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic r);
        v_i = v;
        data_i = d;
        ready_i = r;
    endtask

    task automatic emit_word(input logic [W-1:0] w, input string name);
        for (int k = 0; k < E; k++) begin
            step();
            drive(1'b0, '0, 1'b1);
            @(negedge clk_i);
            chk({name, "_v"}, 32'(v_o), 1);
            chk({name, "_data"}, 32'(data_o), 32'(chunk(w, k)));
            chk({name, "_last"}, 32'(last_o), 32'(k == E - 1));
        end
    endtask

    initial begin
        logic [W-1:0] w0, w1, wr;
        bit done;
        reset_n_i = 1'b0;
        drive(1'b1, 32'h5555_AAAA, 1'b1);
        repeat (5) @(negedge clk_i);

        // Single word
        w0 = 32'hA1B2C3D4;
        step(); reset_n_i = 1'b1; drive(1'b1, w0, 1'b1);
        @(negedge clk_i); chk("single_yumi", 32'(yumi_o), 1);
        emit_word(w0, "single");
        step(); drive(1'b0, '0, 1'b1);
        @(negedge clk_i); chk("single_idle", 32'(v_o), 0);

        // Back-to-back, no bubble, second yumi on the last chunk
        w0 = 32'h03020100; w1 = 32'h07060504;
        step(); drive(1'b1, w0, 1'b1);
        @(negedge clk_i); chk("b2b_yumi0", 32'(yumi_o), 1);
        for (int k = 0; k < 2 * E; k++) begin
            step(); drive(k < E, w1, 1'b1);
            @(negedge clk_i);
            chk("b2b_v", 32'(v_o), 1);
            chk("b2b_data", 32'(data_o), 32'(chunk(k < E ? w0 : w1, k % E)));
            chk("b2b_last", 32'(last_o), 32'(k % E == E - 1));
            chk("b2b_yumi", 32'(yumi_o), 32'(k == E - 1));
        end
        step(); drive(1'b0, '0, 1'b1);
        @(negedge clk_i); chk("b2b_idle", 32'(v_o), 0);

        // Backpressure after chunk 0
        step(); drive(1'b1, w0, 1'b1);
        @(negedge clk_i);
        step(); drive(1'b0, '0, 1'b1);
        @(negedge clk_i); chk("bp_c0", 32'(data_o), 32'(chunk(w0, 0)));
        repeat (3) begin
            step(); drive(1'b1, 32'hFFFF_FFFF, 1'b0);
            @(negedge clk_i);
            chk("bp_hold_v", 32'(v_o), 1);
            chk("bp_hold_data", 32'(data_o), 32'(chunk(w0, 1)));
            chk("bp_hold_yumi", 32'(yumi_o), 0);
        end
        for (int k = 1; k < E; k++) begin
            step(); drive(1'b0, '0, 1'b1);
            @(negedge clk_i);
            chk("bp_resume", 32'(data_o), 32'(chunk(w0, k)));
            chk("bp_resume_last", 32'(last_o), 32'(k == E - 1));
        end
        step(); drive(1'b0, '0, 1'b1);
        @(negedge clk_i); chk("bp_idle", 32'(v_o), 0);

        // Mid-word reset discards the partial word
        step(); drive(1'b1, 32'hDEADBEEF, 1'b1);
        @(negedge clk_i);
        for (int k = 0; k < 2; k++) begin
            step(); drive(1'b0, '0, 1'b1);
            @(negedge clk_i); chk("mr_pre", 32'(data_o), 32'(chunk(32'hDEADBEEF, k)));
        end
        step(); reset_n_i = 1'b0; drive(1'b0, '0, 1'b1);
        @(negedge clk_i);
        step(); reset_n_i = 1'b1;
        @(negedge clk_i); chk("mr_post_v", 32'(v_o), 0);
        w1 = 32'h11223344;
        step(); drive(1'b1, w1, 1'b1);
        @(negedge clk_i); chk("mr_yumi", 32'(yumi_o), 1);
        emit_word(w1, "mr_word");
        step(); drive(1'b0, '0, 1'b1);
        @(negedge clk_i); chk("mr_idle", 32'(v_o), 0);

        // Random traffic against the scoreboard
        for (int i = 0; i < 10000; i++) begin
            step();
            wr = $urandom;
            drive(($urandom % 4) != 0, wr, ($urandom % 4) != 0);
        end

        // Drain with a bounded wait
        done = 1'b0;
        for (int i = 0; i < 4 * E && !done; i++) begin
            step(); drive(1'b0, '0, 1'b1);
            @(negedge clk_i);
            if (!v_o && exp_q.size() == 0) done = 1'b1;
        end
        chk("drain_done", 32'(done), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
